// File: rtl/tempsense_pkg.sv
// Shared types for the temperature-sensor sequencer: FSM state encoding and default result width.
package tempsense_pkg;

   localparam int unsigned DoutWDefault = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_CONV,
      ST_CAPT,
      ST_HOLD,
      ST_WAIT
   } state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk_i domain.
// Latency 2 cycles; no backpressure (free-running sampler).
module prim_flop_2sync #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tempsense_seq.sv
// Sequencer for one on-die temperature sensor: reset pulse, enable, DONE capture, alarm, timeout.
// Result leaves via a single-entry valid/ready slot; a blocked slot parks the FSM in HOLD.
module tempsense_seq
   import tempsense_pkg::*;
#(
   parameter int unsigned RstCycles = 4,
   parameter int unsigned TimeoutW  = 20,
   parameter int unsigned DoutW     = DoutWDefault
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             periodic_en_i,
   input  logic [15:0]      interval_i,
   input  logic [3:0]       conv_time_i,
   input  logic [DoutW-1:0] threshold_hi_i,
   input  logic             clear_err_i,
   output logic             sns_rst_no,
   output logic             sns_en_o,
   output logic [3:0]       sns_sel_conv_time_o,
   input  logic             sns_done_i,
   input  logic [DoutW-1:0] sns_dout_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [DoutW-1:0] result_o,
   output logic             busy_o,
   output logic             alarm_o,
   output logic             timeout_err_o
);

   localparam int unsigned RstCntW = (RstCycles > 1) ? $clog2(RstCycles) : 1;

   state_e              state_q, state_d, load_next;
   logic [RstCntW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [TimeoutW-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
   logic [15:0]         wait_cnt_q, wait_cnt_d;
   logic [3:0]          conv_time_q, conv_time_d;
   logic [DoutW-1:0]    cap_q, cap_d, result_q, result_d;
   logic                valid_q, valid_d, alarm_q, alarm_d, err_q, err_d;
   logic                sns_rst_n_q, sns_rst_n_d, per_done_q, per_done_d, done_prev_q;
   logic                done_sync, done_rise, slot_free, wait_last;

   prim_flop_2sync #(.Width(1)) u_done_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (sns_done_i),
      .q_o   (done_sync)
   );

   assign done_rise  = done_sync & ~done_prev_q;
   assign slot_free  = ~valid_q | result_ready_i;
   assign to_cnt_inc = to_cnt_q + 1'b1;
   assign wait_last  = ({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, interval_i};

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      to_cnt_d    = '0;
      wait_cnt_d  = '0;
      conv_time_d = conv_time_q;
      cap_d       = cap_q;
      result_d    = result_q;
      valid_d     = valid_q & ~result_ready_i;
      alarm_d     = alarm_q;
      err_d       = err_q & ~clear_err_i;
      // Interval 0 skips WAIT entirely so periodic conversions run back to back.
      load_next   = ST_IDLE;
      if (periodic_en_i) begin
         load_next = (interval_i == 16'd0) ? ST_RST : ST_WAIT;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start_i || (periodic_en_i && !per_done_q)) begin
               state_d = ST_RST;
            end
         end
         ST_RST: begin
            if (rst_cnt_q == RstCntW'(RstCycles - 1)) begin
               rst_cnt_d = '0;
               state_d   = ST_CONV;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         ST_CONV: begin
            to_cnt_d = to_cnt_inc;
            if (done_rise) begin
               state_d = ST_CAPT;
            end else if (&to_cnt_inc) begin
               err_d   = 1'b1;
               state_d = periodic_en_i ? ST_WAIT : ST_IDLE;
            end
         end
         ST_CAPT: begin
            cap_d   = sns_dout_i;
            alarm_d = sns_dout_i > threshold_hi_i;
            if (slot_free) begin
               result_d = sns_dout_i;
               valid_d  = 1'b1;
               state_d  = load_next;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (slot_free) begin
               result_d = cap_q;
               valid_d  = 1'b1;
               state_d  = load_next;
            end
         end
         ST_WAIT: begin
            if (!periodic_en_i) begin
               state_d = ST_IDLE;
            end else if (wait_last) begin
               state_d = ST_RST;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_RST) && (state_q != ST_RST)) begin
         conv_time_d = conv_time_i;
         rst_cnt_d   = '0;
      end

      // The sensor reset stays low after power-up until the first RST phase completes.
      sns_rst_n_d = sns_rst_n_q;
      if (state_d == ST_RST) begin
         sns_rst_n_d = 1'b0;
      end else if (state_q == ST_RST) begin
         sns_rst_n_d = 1'b1;
      end

      per_done_d = periodic_en_i & (per_done_q | (state_d == ST_RST));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rst_cnt_q   <= '0;
         to_cnt_q    <= '0;
         wait_cnt_q  <= '0;
         conv_time_q <= '0;
         cap_q       <= '0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         alarm_q     <= 1'b0;
         err_q       <= 1'b0;
         sns_rst_n_q <= 1'b0;
         per_done_q  <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         to_cnt_q    <= to_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         conv_time_q <= conv_time_d;
         cap_q       <= cap_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
         alarm_q     <= alarm_d;
         err_q       <= err_d;
         sns_rst_n_q <= sns_rst_n_d;
         per_done_q  <= per_done_d;
         done_prev_q <= done_sync;
      end
   end

   assign sns_rst_no          = sns_rst_n_q;
   assign sns_en_o            = (state_q == ST_CONV);
   assign sns_sel_conv_time_o = conv_time_q;
   assign result_valid_o      = valid_q;
   assign result_o            = result_q;
   assign busy_o              = (state_q != ST_IDLE);
   assign alarm_o             = alarm_q;
   assign timeout_err_o       = err_q;

endmodule

// File: tb/tb_tempsense_seq.sv
// Bench for tempsense_seq: behavioural sensor, result scoreboard, vector table plus corner sequences.
module tb_tempsense_seq;

   localparam int RST_CYC = 4;
   localparam int TO_W    = 8;
   localparam int DW      = 24;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          periodic_en_i;
   logic [15:0]   interval_i;
   logic [3:0]    conv_time_i;
   logic [DW-1:0] threshold_hi_i;
   logic          clear_err_i;
   logic          sns_rst_no;
   logic          sns_en_o;
   logic [3:0]    sns_sel_conv_time_o;
   logic          sns_done_i;
   logic [DW-1:0] sns_dout_i;
   logic          result_valid_o;
   logic          result_ready_i;
   logic [DW-1:0] result_o;
   logic          busy_o;
   logic          alarm_o;
   logic          timeout_err_o;

   tempsense_seq #(.RstCycles(RST_CYC), .TimeoutW(TO_W), .DoutW(DW)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .start_i             (start_i),
      .periodic_en_i       (periodic_en_i),
      .interval_i          (interval_i),
      .conv_time_i         (conv_time_i),
      .threshold_hi_i      (threshold_hi_i),
      .clear_err_i         (clear_err_i),
      .sns_rst_no          (sns_rst_no),
      .sns_en_o            (sns_en_o),
      .sns_sel_conv_time_o (sns_sel_conv_time_o),
      .sns_done_i          (sns_done_i),
      .sns_dout_i          (sns_dout_i),
      .result_valid_o      (result_valid_o),
      .result_ready_i      (result_ready_i),
      .result_o            (result_o),
      .busy_o              (busy_o),
      .alarm_o             (alarm_o),
      .timeout_err_o       (timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   int            sns_done_delay = 0;
   logic [DW-1:0] sns_val = '0;
   int            en_cnt = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_res = '0;

   typedef struct {
      logic [DW-1:0] dout;
      logic [DW-1:0] thr;
      int            dly;
      bit            alarm;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sensor: DONE rises dly enabled cycles into a conversion, drops while its reset is low.
   initial begin
      sns_done_i = 1'b0;
      sns_dout_i = '0;
      forever begin
         @(posedge clk_i);
         #2;
         if (!sns_rst_no) begin
            sns_done_i = 1'b0;
            en_cnt = 0;
         end else if (sns_en_o) begin
            en_cnt++;
            if (sns_done_delay != 0 && en_cnt == sns_done_delay) begin
               sns_dout_i = sns_val;
               sns_done_i = 1'b1;
            end
         end else begin
            en_cnt = 0;
         end
      end
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold && result_valid_o) check("result_stable", result_o, prev_res);
         if (result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL unexpected_result: got %0h expected none", result_o);
            end else begin
               check("scoreboard_result", result_o, exp_q.pop_front());
            end
         end
         prev_hold <= result_valid_o && !result_ready_i;
         prev_res  <= result_o;
      end
   end

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_i);
         if (result_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_i);
      #1 start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
   endtask

   task automatic run_conv(input logic [DW-1:0] val, input logic [DW-1:0] thr, input int dly,
                           input bit exp_alarm, input string tag);
      int lat, conv, rlow;
      bit got;
      sns_val = val;
      threshold_hi_i = thr;
      sns_done_delay = dly;
      exp_q.push_back(val);
      @(posedge clk_i);
      #1 start_i = 1'b1;
      @(negedge clk_i);
      @(posedge clk_i);
      #1 start_i = 1'b0;
      lat = 0; conv = 0; rlow = 0; got = 1'b0;
      while (!got && lat < 2000) begin
         @(negedge clk_i);
         lat++;
         if (sns_en_o) conv++;
         if (busy_o && !sns_rst_no) rlow++;
         if (result_valid_o) got = 1'b1;
      end
      check({tag, "_valid_seen"}, got, 1);
      check({tag, "_rst_low_cycles"}, rlow, RST_CYC);
      check({tag, "_latency"}, lat + 1, 1 + RST_CYC + conv + 2);
      @(negedge clk_i);
      check({tag, "_alarm"}, alarm_o, exp_alarm);
      check({tag, "_busy_idle"}, busy_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got, vseen;
      int conv;
      vecs[0] = '{24'h001234, 24'h002000, 100, 1'b0};
      vecs[1] = '{24'h003000, 24'h002000, 20,  1'b1};
      vecs[2] = '{24'h001000, 24'h002000, 20,  1'b0};
      vecs[3] = '{24'h002000, 24'h002000, 5,   1'b0};
      vecs[4] = '{24'h002001, 24'h002000, 5,   1'b1};
      vecs[5] = '{24'hFFFFFF, 24'hFFFFFE, 3,   1'b1};

      rst_i = 1'b1; start_i = 1'b0; periodic_en_i = 1'b0; interval_i = '0;
      conv_time_i = 4'hA; threshold_hi_i = '0; clear_err_i = 1'b0; result_ready_i = 1'b1;
      #23;
      check("reset_outputs", {sns_rst_no, sns_en_o, sns_sel_conv_time_o, result_valid_o,
                              result_o, alarm_o, timeout_err_o, busy_o}, 64'd0);
      @(negedge clk_i) rst_i = 1'b0;
      repeat (2) @(negedge clk_i);

      for (int v = 0; v < 6; v++) begin
         run_conv(vecs[v].dout, vecs[v].thr, vecs[v].dly, vecs[v].alarm, $sformatf("vec%0d", v));
      end
      check("conv_time_latched", sns_sel_conv_time_o, 4'hA);

      // Backpressure: second periodic conversion must park behind the unread first result.
      result_ready_i = 1'b0; interval_i = 16'd10; threshold_hi_i = 24'h002000;
      sns_done_delay = 20; sns_val = 24'h000111;
      exp_q.push_back(24'h000111);
      exp_q.push_back(24'h004444);
      @(negedge clk_i) periodic_en_i = 1'b1;
      wait_valid(200, got);
      check("bp_first_valid", got, 1);
      sns_val = 24'h004444;
      repeat (50) @(negedge clk_i);
      check("bp_first_held", result_o, 24'h000111);
      check("bp_hold_state", {result_valid_o, busy_o, sns_en_o}, 3'b110);
      check("bp_alarm_second", alarm_o, 1);
      periodic_en_i = 1'b0;
      @(posedge clk_i);
      #1 result_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      check("bp_second_next", {result_valid_o, result_o}, {1'b1, 24'h004444});
      @(negedge clk_i);
      check("bp_idle_after", busy_o, 0);

      // Timeout with clear held high: the set must still win.
      sns_done_delay = 0;
      clear_err_i = 1'b1;
      pulse_start();
      conv = 0; got = 1'b0; vseen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk_i);
         if (sns_en_o) conv++;
         if (result_valid_o) vseen = 1'b1;
         if (timeout_err_o) begin
            got = 1'b1;
            break;
         end
      end
      clear_err_i = 1'b0;
      check("to_set_over_clear", got, 1);
      check("to_conv_cycles", conv, 255);
      check("to_en_dropped", sns_en_o, 0);
      check("to_no_result", vseen, 0);
      repeat (3) @(negedge clk_i);
      check("to_sticky", {timeout_err_o, busy_o}, 2'b10);
      @(posedge clk_i);
      #1 clear_err_i = 1'b1;
      @(posedge clk_i);
      #1 clear_err_i = 1'b0;
      @(negedge clk_i);
      check("to_cleared", timeout_err_o, 0);

      // Asynchronous reset in the middle of a conversion.
      sns_done_delay = 50;
      pulse_start();
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (sns_en_o) begin
            got = 1'b1;
            break;
         end
      end
      check("arst_reached_conv", got, 1);
      repeat (5) @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      check("arst_outputs", {sns_rst_no, sns_en_o, sns_sel_conv_time_o, result_valid_o,
                             result_o, alarm_o, timeout_err_o, busy_o}, 64'd0);
      @(negedge clk_i) rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      run_conv(24'h000ABC, 24'h000100, 10, 1'b1, "post_rst");

      // Periodic with zero interval, then a non-zero interval and drop in WAIT.
      interval_i = 16'd0; threshold_hi_i = 24'h002000; sns_val = 24'h000777; sns_done_delay = 5;
      for (int k = 0; k < 3; k++) exp_q.push_back(24'h000777);
      @(negedge clk_i) periodic_en_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(200, got);
         check($sformatf("p0_valid%0d", k), got, 1);
         if (k < 2) check($sformatf("p0_rst_after_load%0d", k), {sns_rst_no, busy_o}, 2'b01);
         if (k == 1) interval_i = 16'd20;
      end
      repeat (3) @(negedge clk_i);
      check("p0_wait_busy", {busy_o, sns_rst_no, sns_en_o}, 3'b110);
      periodic_en_i = 1'b0;
      @(negedge clk_i);
      check("p0_idle_next", busy_o, 0);

      repeat (5) @(negedge clk_i);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tempsense_seq.md
TEMPSENSE_SEQ -- requirements
Module: tempsense_seq

Interface
REQ-001 Parameter RstCycles, default 4, SHALL be the number of cycles sns_rst_no is held low before each conversion.
REQ-002 Parameter TimeoutW, default 20, SHALL be the conversion timeout counter width; timeout = 2^TimeoutW-1 cycles.
REQ-003 Parameter DoutW, default 24, SHALL be the sensor result width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  block clock, rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  single-cycle request for one conversion; ignored unless IDLE.
REQ-008 periodic_en_i  in  1  level; when high, conversions repeat after interval_i cycles.
REQ-009 interval_i  in  16  idle cycles between periodic conversions.
REQ-010 conv_time_i  in  4  conversion-time select; latched at conversion start.
REQ-011 threshold_hi_i  in  DoutW  alarm threshold.
REQ-012 clear_err_i  in  1  clears timeout_err_o.
REQ-013 sns_rst_no  out  1  active-low sensor counter reset.
REQ-014 sns_en_o  out  1  sensor enable.
REQ-015 sns_sel_conv_time_o  out  4  latched conv_time_i.
REQ-016 sns_done_i  in  1  asynchronous sensor DONE.
REQ-017 sns_dout_i  in  DoutW  sensor result, stable while DONE high.
REQ-018 result_valid_o / result_ready_i / result_o  out/in/out  1/1/DoutW  single-entry result slot, valid/ready.
REQ-019 busy_o, alarm_o, timeout_err_o  out  1 each  not-IDLE; last result > threshold; sticky timeout.

Function
REQ-020 FSM states SHALL be IDLE, RST, CONV, CAPT, HOLD, WAIT.
REQ-021 IDLE: start_i=1, or periodic_en_i=1 with no prior conversion since it rose, SHALL go to RST next cycle and latch conv_time_i.
REQ-022 RST SHALL drive sns_rst_no=0 for exactly RstCycles cycles, then go to CONV.
REQ-023 CONV SHALL drive sns_en_o=1 and clear/advance the timeout counter each cycle.
REQ-024 sns_done_i SHALL pass a 2-flop synchronizer; a synchronized 0->1 edge in CONV SHALL move to CAPT.
REQ-025 CAPT SHALL sample sns_dout_i into a capture register, drop sns_en_o, and update alarm_o = (capture > threshold_hi_i), unsigned compare.
REQ-026 If the slot is empty or result_ready_i=1 in CAPT, result_o SHALL load and result_valid_o assert the following cycle; otherwise the FSM SHALL wait in HOLD until the slot frees.
REQ-027 result_valid_o SHALL stay high with result_o stable until result_valid_o & result_ready_i; a result SHALL never be dropped or overwritten.
REQ-028 After loading: periodic_en_i=1 -> WAIT; else IDLE.
REQ-029 WAIT SHALL count interval_i cycles then go to RST; interval_i=0 SHALL go to RST directly; periodic_en_i=0 during WAIT SHALL return to IDLE next cycle.
REQ-030 Timeout counter reaching all-ones in CONV SHALL set timeout_err_o, drop sns_en_o, go to WAIT if periodic_en_i else IDLE; no result is produced.
REQ-031 clear_err_i and timeout in same cycle: set SHALL win.
REQ-032 busy_o SHALL be 1 in every state except IDLE; start_i while busy SHALL be ignored, not queued.
REQ-033 End-to-end latency: start_i to result_valid_o = 1 + RstCycles + (cycles in CONV) + 2 cycles with slot empty.

Reset
REQ-034 rst_i SHALL force, asynchronously: state IDLE, sns_rst_no=0, sns_en_o=0, sns_sel_conv_time_o=0, result_valid_o=0, result_o=0, alarm_o=0, timeout_err_o=0, busy_o=0, counters and synchronizer 0.
REQ-035 Reset mid-conversion SHALL abandon it; sns_rst_no SHALL rise only when RST exits after the next start.

Structure
REQ-036 tempsense_pkg SHALL hold the FSM state enum and the DoutW default constant.
REQ-037 The DONE synchronizer SHALL be one instance of prim_flop_2sync; all other logic SHALL be in tempsense_seq.

Verification
REQ-038 start_i pulse, DONE after 100 cycles, dout=24'h00_1234, threshold 24'h00_2000 -> sns_rst_no low 4 cycles, result_o=24'h001234 valid, alarm_o=0, busy_o back to 0.
REQ-039 result_ready_i=0 for 50 cycles with periodic_en_i=1, interval_i=10 -> second conversion completes, FSM holds in HOLD, first result unchanged, second delivered right after first handshake.
REQ-040 TimeoutW=8, DONE never asserts -> timeout_err_o=1 at cycle 255 of CONV, sns_en_o=0, no result_valid_o; clear_err_i same cycle -> still 1; clear later -> 0.
REQ-041 dout=24'h00_3000, threshold 24'h00_2000 -> alarm_o=1; next result 24'h00_1000 -> alarm_o=0.
REQ-042 rst_i asserted in CONV -> all outputs at reset values asynchronously; start_i after release -> clean conversion.
REQ-043 periodic_en_i=1, interval_i=0 -> back-to-back conversions, RST entered the cycle after each load; periodic_en_i dropped in WAIT -> IDLE next cycle.
